mem_stage: RTL and testbench

//  Memory-access pipeline stage between the execute stage and wb_stage.
//  - Receives load/store requests already issued to the data SRAM by EX; waits for data_sram_data_ok.
//  - Aligns and extends load data, then hands the {csr fields, gr_we, dest, result, pc} bus to WB.
//  - Carries the valid/allowin handshake and a flush that drops in-flight responses.

---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data SRAM responses, aligns load data, hands off to WB.
// Optional build macro MS_FWD_EN enables forwarding of MS results to decode.
module mem_stage #(
    parameter int unsigned CSR_WD      = 80,
    parameter int unsigned ES_TO_MS_WD = CSR_WD + 78,
    parameter int unsigned MS_TO_WS_WD = CSR_WD + 70
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
    output logic                   ms_allowin,
    input  logic                   ws_allowin,
    output logic                   ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ms_flush,
    output logic [38:0]            ms_to_ds_bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold,
        StDiscard
    } state_e;

    state_e state_q, state_d;

    logic                   ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_WD-2:0] es_bus_q, es_bus_d;
    logic [31:0]            data_buf_q, data_buf_d;

    // Top bit of the EX bus carries no field.
    logic unused_es_spare;
    assign unused_es_spare = es_to_ms_bus[ES_TO_MS_WD-1];

    // Latched instruction fields
    logic [CSR_WD-1:0] ms_csr;
    logic              ms_mem_req;
    logic              ms_res_from_mem;
    logic [2:0]        ms_ld_op;
    logic [1:0]        ms_addr_low;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [31:0]       ms_alu_result;
    logic [31:0]       ms_pc;

    assign ms_pc           = es_bus_q[31:0];
    assign ms_alu_result   = es_bus_q[63:32];
    assign ms_dest         = es_bus_q[68:64];
    assign ms_gr_we        = es_bus_q[69];
    assign ms_addr_low     = es_bus_q[71:70];
    assign ms_ld_op        = es_bus_q[74:72];
    assign ms_res_from_mem = es_bus_q[75];
    assign ms_mem_req      = es_bus_q[76];
    assign ms_csr          = es_bus_q[CSR_WD+76:77];

    logic in_mem_req;
    assign in_mem_req = es_to_ms_bus[76];

    // Handshake
    logic data_buf_valid;
    logic ms_ready_go;
    logic accept;

    assign data_buf_valid = (state_q == StHold);
    assign ms_ready_go    = ~ms_mem_req | data_sram_data_ok | data_buf_valid;
    assign ms_allowin     = (state_q != StDiscard) & (~ms_valid_q | (ms_ready_go & ws_allowin));
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign accept         = es_to_ms_valid & ms_allowin & ~ms_flush;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ms_valid_d = ms_valid_q;
        es_bus_d   = es_bus_q;
        data_buf_d = data_buf_q;

        case (state_q)
            StDiscard: begin
                // The response owed to the flushed instruction is swallowed here.
                if (data_sram_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (ms_flush) begin
                    ms_valid_d = 1'b0;
                    if ((state_q == StWait) && !data_sram_data_ok) begin
                        state_d = StDiscard;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (ms_allowin) begin
                    ms_valid_d = es_to_ms_valid;
                    if (accept) begin
                        es_bus_d = es_to_ms_bus[ES_TO_MS_WD-2:0];
                        state_d  = in_mem_req ? StWait : StIdle;
                    end else begin
                        state_d = StIdle;
                    end
                end else if ((state_q == StWait) && data_sram_data_ok) begin
                    // WB is stalled; keep the response since the SRAM will not repeat it.
                    state_d    = StHold;
                    data_buf_d = data_sram_rdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ms_valid_q <= 1'b0;
            es_bus_q   <= '0;
            data_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            ms_valid_q <= ms_valid_d;
            es_bus_q   <= es_bus_d;
            data_buf_q <= data_buf_d;
        end
    end

    // Load alignment and extension
    logic [31:0] mem_rdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] final_result;

    assign mem_rdata = data_buf_valid ? data_buf_q : data_sram_rdata;

    always_comb begin
        load_byte = 8'(mem_rdata >> {ms_addr_low, 3'b000});
        load_half = 16'(mem_rdata >> {ms_addr_low[1], 4'b0000});
        case (ms_ld_op)
            3'b001:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_ext = {{16{load_half[15]}}, load_half};
            3'b011:  load_ext = {24'h0, load_byte};
            3'b100:  load_ext = {16'h0, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    assign final_result = ms_res_from_mem ? load_ext : ms_alu_result;

    assign ms_to_ws_bus = {ms_csr, ms_gr_we, ms_dest, final_result, ms_pc};

    // Decode-side hazard information
    logic        ms_blk;
    logic        ms_fwd_we;
    logic [31:0] fwd_data;

`ifdef MS_FWD_EN
    assign ms_blk    = ms_valid_q & ms_res_from_mem & ~ms_ready_go;
    assign ms_fwd_we = ms_valid_q & ms_gr_we & ms_ready_go;
    assign fwd_data  = final_result;
`else
    assign ms_blk    = ms_valid_q & ms_gr_we;
    assign ms_fwd_we = 1'b0;
    assign fwd_data  = 32'h0;
`endif

    assign ms_to_ds_bus = {ms_blk, ms_fwd_we, ms_dest, fwd_data};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// checked against a behavioural load/forwarding model.
module tb_mem_stage;

    localparam int unsigned CSR_WD      = 80;
    localparam int unsigned ES_TO_MS_WD = CSR_WD + 78;
    localparam int unsigned MS_TO_WS_WD = CSR_WD + 70;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   es_to_ms_valid;
    logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
    logic                   ms_allowin;
    logic                   ws_allowin;
    logic                   ms_to_ws_valid;
    logic [MS_TO_WS_WD-1:0] ms_to_ws_bus;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;
    logic                   ms_flush;
    logic [38:0]            ms_to_ds_bus;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(
        .CSR_WD     (CSR_WD),
        .ES_TO_MS_WD(ES_TO_MS_WD),
        .MS_TO_WS_WD(MS_TO_WS_WD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .ms_allowin       (ms_allowin),
        .ws_allowin       (ws_allowin),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .ms_flush         (ms_flush),
        .ms_to_ds_bus     (ms_to_ds_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CSR_WD-1:0] csr;
        logic              mreq;
        logic              rfm;
        logic [2:0]        op;
        logic [1:0]        al;
        logic              gr;
        logic [4:0]        dst;
        logic [31:0]       alu;
        logic [31:0]       pc;
        logic [31:0]       rd;
    } txn_t;

    // Reference load result from plain arithmetic on the fetched word.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] al,
                                             input logic [31:0] rd);
        longint unsigned w, b, h, r;
        int unsigned     idx;
        idx = al;
        w   = rd;
        b   = (w / (64'd1 << (8 * idx))) % 256;
        h   = (w / (64'd1 << (16 * (idx / 2)))) % 65536;
        case (op)
            3'd1:    r = (b < 128) ? b : b + 64'hFFFF_FF00;
            3'd2:    r = (h < 32768) ? h : h + 64'hFFFF_0000;
            3'd3:    r = b;
            3'd4:    r = h;
            default: r = w;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [31:0] ref_result(input txn_t t);
        return t.rfm ? ref_load(t.op, t.al, t.rd) : t.alu;
    endfunction

    function automatic logic [ES_TO_MS_WD-1:0] mk_bus(input txn_t t);
        return {1'b0, t.csr, t.mreq, t.rfm, t.op, t.al, t.gr, t.dst, t.alu, t.pc};
    endfunction

    function automatic logic [MS_TO_WS_WD-1:0] exp_ws(input txn_t t);
        return {t.csr, t.gr, t.dst, ref_result(t), t.pc};
    endfunction

    function automatic logic [38:0] exp_ds(input txn_t t, input logic ready);
`ifdef MS_FWD_EN
        return {t.rfm & ~ready, t.gr & ready, t.dst, ref_result(t)};
`else
        return {t.gr, 1'b0, t.dst, 32'h0};
`endif
    endfunction

    function automatic txn_t mk_txn(input logic mreq, input logic rfm, input logic [2:0] op,
                                    input logic [1:0] al, input logic [31:0] alu,
                                    input logic [31:0] rd);
        txn_t t;
        t.csr  = CSR_WD'({$urandom, $urandom, $urandom});
        t.mreq = mreq;
        t.rfm  = rfm;
        t.op   = op;
        t.al   = al;
        t.gr   = 1'b1;
        t.dst  = 5'($urandom_range(1, 31));
        t.alu  = alu;
        t.pc   = $urandom;
        t.rd   = rd;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ms_flush          = 1'b0;
    endtask

    // Drives one instruction through an idle stage: lat cycles of waiting, then
    // `stall` cycles of WB back-pressure starting with the response cycle.
    task automatic do_txn(input txn_t t, input int lat, input int stall, input string tag);
        logic [38:0] eds;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_bus(t);
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        #1;
        n_checks++;
        if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: allowin=%b valid=%b, want allowin=1 valid=0",
                     tag, ms_allowin, ms_to_ws_valid);
        end
        step();
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        if (t.mreq) begin
            for (int i = 0; i < lat; i++) begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
                ws_allowin        = 1'($urandom_range(0, 1));
                #1;
                eds = exp_ds(t, 1'b0);
                n_checks++;
                if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0 ||
                    ms_to_ds_bus[38:32] !== eds[38:32]) begin
                    n_fail++;
                    $display("FAIL %s wait%0d: valid=%b allowin=%b ds_hi=%h, want 0 0 %h",
                             tag, i, ms_to_ws_valid, ms_allowin, ms_to_ds_bus[38:32],
                             eds[38:32]);
                end
                step();
            end
        end
        for (int i = 0; i <= stall; i++) begin
            data_sram_data_ok = t.mreq && (i == 0);
            data_sram_rdata   = (i == 0) ? t.rd : $urandom;
            ws_allowin        = (i == stall);
            #1;
            eds = exp_ds(t, 1'b1);
            n_checks++;
            if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(t) ||
                ms_allowin !== ws_allowin || ms_to_ds_bus !== eds) begin
                n_fail++;
                $display("FAIL %s deliver%0d: valid=%b res=%h allowin=%b ds=%h, want 1 %h %b %h",
                         tag, i, ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin, ms_to_ds_bus,
                         ref_result(t), ws_allowin, eds);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_to_ds_bus !== 39'h0) begin
            n_fail++;
            $display("FAIL reset: valid=%b allowin=%b ds=%h, want 0 1 0",
                     ms_to_ws_valid, ms_allowin, ms_to_ds_bus);
        end
        step();
    endtask

    task automatic test_load_ext();
        do_txn(mk_txn(1'b1, 1'b1, 3'd1, 2'd3, 32'h0, 32'h80FF_1234), 0, 0, "ld_b_al3");
        n_checks++;
        if (ref_load(3'd1, 2'd3, 32'h80FF_1234) !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL model_ld_b: got %h want ffffff80", ref_load(3'd1, 2'd3, 32'h80FF_1234));
        end
        do_txn(mk_txn(1'b1, 1'b1, 3'd4, 2'd2, 32'h0, 32'h80FF_1234), 1, 0, "ld_hu_al2");
        do_txn(mk_txn(1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h80FF_1234), 0, 0, "ld_h_al0");
        do_txn(mk_txn(1'b1, 1'b1, 3'd3, 2'd1, 32'h0, 32'h1234_9A78), 0, 0, "ld_bu_al1");
        do_txn(mk_txn(1'b1, 1'b1, 3'd2, 2'd2, 32'h0, 32'h9A78_1234), 0, 0, "ld_h_al2");
        do_txn(mk_txn(1'b1, 1'b1, 3'd7, 2'd1, 32'h0, 32'hDEAD_BEEF), 0, 0, "ld_other");
    endtask

    task automatic test_late_response();
        do_txn(mk_txn(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'hA5A5_0F0F), 3, 0, "late3");
    endtask

    task automatic test_hold();
        do_txn(mk_txn(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'hCAFE_F00D), 0, 2, "hold_w");
        do_txn(mk_txn(1'b1, 1'b1, 3'd1, 2'd2, 32'h0, 32'h00C3_0000), 1, 1, "hold_b");
    endtask

    task automatic test_flush();
        txn_t t;
        // Flush while waiting: response two cycles later must be dropped.
        t = mk_txn(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h1111_2222);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(t);
        step();
        es_to_ms_valid = 1'b0;
        ms_flush       = 1'b1;
        #1;
        n_checks++;
        if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: allowin=%b valid=%b want 0 0", ms_allowin, ms_to_ws_valid);
        end
        step();
        ms_flush = 1'b0;
        #1;
        n_checks++;
        if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL discard: allowin=%b valid=%b want 0 0", ms_allowin, ms_to_ws_valid);
        end
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = $urandom;
        #1;
        n_checks++;
        if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_ok: allowin=%b valid=%b want 0 0", ms_allowin, ms_to_ws_valid);
        end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        n_checks++;
        if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_discard: allowin=%b valid=%b want 1 0",
                     ms_allowin, ms_to_ws_valid);
        end
        step();

        // Flush in the same cycle as the response: no discard state afterwards.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(t);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        ms_flush          = 1'b1;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_with_ok: allowin=%b valid=%b want 1 0",
                     ms_allowin, ms_to_ws_valid);
        end
        step();

        // Flush blocks a same-cycle accept.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(mk_txn(1'b0, 1'b0, 3'd0, 2'd0, 32'h7777_0000, 32'h0));
        ms_flush       = 1'b1;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_accept: allowin=%b valid=%b want 1 0",
                     ms_allowin, ms_to_ws_valid);
        end
        step();

        // Flush while a buffered response waits for WB.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(t);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        ws_allowin        = 1'b0;
        step();
        data_sram_data_ok = 1'b0;
        ms_flush          = 1'b1;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_hold: allowin=%b valid=%b want 1 0", ms_allowin, ms_to_ws_valid);
        end
        step();
    endtask

    task automatic test_alu();
        do_txn(mk_txn(1'b0, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0), 0, 0, "alu");
        do_txn(mk_txn(1'b1, 1'b0, 3'd0, 2'd1, 32'h0000_1000, 32'hFFFF_FFFF), 2, 1, "store");
    endtask

    task automatic test_back_to_back();
        txn_t a, b, c;
        a = mk_txn(1'b0, 1'b0, 3'd0, 2'd0, 32'hAAAA_0001, 32'h0);
        b = mk_txn(1'b1, 1'b1, 3'd3, 2'd3, 32'h0, 32'h5500_0000 | 32'($urandom_range(0, 255)));
        c = mk_txn(1'b0, 1'b0, 3'd0, 2'd0, 32'hCCCC_0003, 32'h0);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(a);
        step();
        es_to_ms_bus = mk_bus(b);
        #1;
        n_checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(a) || ms_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_a: valid=%b res=%h allowin=%b want 1 %h 1",
                     ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin, ref_result(a));
        end
        step();
        es_to_ms_bus      = mk_bus(c);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = b.rd;
        #1;
        n_checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(b) || ms_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_b: valid=%b res=%h allowin=%b want 1 %h 1",
                     ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin, ref_result(b));
        end
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
        #1;
        n_checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(c)) begin
            n_fail++;
            $display("FAIL b2b_c: valid=%b res=%h want 1 %h",
                     ms_to_ws_valid, ms_to_ws_bus[63:32], ref_result(c));
        end
        step();
        #1;
        n_checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_drain: valid=%b allowin=%b want 0 1", ms_to_ws_valid, ms_allowin);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_wait();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(mk_txn(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0));
        step();
        es_to_ms_valid = 1'b0;
        reset          = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_to_ds_bus !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: valid=%b allowin=%b ds=%h want 0 1 0",
                     ms_to_ws_valid, ms_allowin, ms_to_ds_bus);
        end
        step();
        do_txn(mk_txn(1'b0, 1'b0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0), 0, 0, "post_reset");
    endtask

    task automatic test_random();
        txn_t t;
        int   kind;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            t = mk_txn(kind != 0, kind == 1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       $urandom, $urandom);
            t.gr = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            do_txn(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_ext();
        test_late_response();
        test_hold();
        test_flush();
        test_alu();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
